// File: rtl/proc_mem_pkg.sv
// Shared memory-request definitions for the TinyRV1 processor memories.
package proc_mem_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  function automatic logic [29:0] word_of(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/proc_mem_array.sv
// Word storage: two combinational read ports, preload and data write ports.
module mem_array #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] ra_idx,
  output logic [31:0]   ra_data,
  input  logic [AW-1:0] rb_idx,
  output logic [31:0]   rb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [WORDS];

  assign ra_data = mem[ra_idx];
  assign rb_data = mem[rb_idx];

  // Preload is applied last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
    if (ld_en)
      mem[ld_idx] <= ld_data;
  end

endmodule

// File: rtl/proc_mem.sv
// Instruction/data memory responder with preload, MMIO output,
// request counters and sticky access-error capture.
module proc_mem
  import proc_mem_pkg::*;
#(
  parameter int          WORDS    = 256,
  parameter logic [31:0] OUT_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        out_val,
  output logic [31:0] out_data,
  output logic [31:0] ireq_count,
  output logic [31:0] dreq_count,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int          AW     = $clog2(WORDS);
  localparam logic [29:0] NWORDS = 30'(WORDS);

  logic [29:0] i_word, d_word, ld_word;
  logic        i_ok, d_ok, d_out, ld_ok;
  logic        i_err, d_err;
  logic        d_wr, wr_en;
  logic [31:0] ra_data, rb_data;

  assign i_word  = word_of(imemreq_addr);
  assign d_word  = word_of(dmemreq_addr);
  assign ld_word = word_of(ld_addr);

  assign i_ok  = is_aligned(imemreq_addr) && (i_word < NWORDS);
  assign d_ok  = is_aligned(dmemreq_addr) && (d_word < NWORDS);
  assign d_out = dmemreq_addr == OUT_ADDR;
  assign ld_ok = ld_en && (ld_word < NWORDS);

  assign i_err = imemreq_val && !i_ok;
  assign d_err = dmemreq_val && !d_ok && !d_out;
  assign d_wr  = dmemreq_val && (dmemreq_type == MEM_REQ_WRITE);
  assign wr_en = rst && d_wr && d_ok;

  mem_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .ra_idx  (i_word[AW-1:0]),
    .ra_data (ra_data),
    .rb_idx  (d_word[AW-1:0]),
    .rb_data (rb_data),
    .ld_en   (ld_ok),
    .ld_idx  (ld_word[AW-1:0]),
    .ld_data (ld_data),
    .wr_en   (wr_en),
    .wr_idx  (d_word[AW-1:0]),
    .wr_data (dmemreq_wdata)
  );

  assign imemresp_data = (imemreq_val && i_ok) ? ra_data : 32'h0;

  always_comb begin
    dmemresp_rdata = 32'h0;
    if (dmemreq_val) begin
      unique case (1'b1)
        d_ok:    dmemresp_rdata = rb_data;
        d_out:   dmemresp_rdata = out_data;
        default: dmemresp_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ireq_count <= 32'h0;
      dreq_count <= 32'h0;
      out_val    <= 1'b0;
      out_data   <= 32'h0;
      err        <= 1'b0;
      err_addr   <= 32'h0;
    end else begin
      if (imemreq_val)
        ireq_count <= ireq_count + 32'd1;
      if (dmemreq_val)
        dreq_count <= dreq_count + 32'd1;
      out_val <= d_wr && d_out;
      if (d_wr && d_out)
        out_data <= dmemreq_wdata;
      // Fetch address takes precedence when both ports fault together.
      if (!err && (i_err || d_err)) begin
        err      <= 1'b1;
        err_addr <= i_err ? imemreq_addr : dmemreq_addr;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem.sv
// Directed self-checking bench for proc_mem.
module tb_proc_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        out_val;
  logic [31:0] out_data;
  logic [31:0] ireq_count;
  logic [31:0] dreq_count;
  logic        err;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  proc_mem dut (
    .clk            (clk),
    .rst            (rst),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .out_val        (out_val),
    .out_data       (out_data),
    .ireq_count     (ireq_count),
    .dreq_count     (dreq_count),
    .err            (err),
    .err_addr       (err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dreq(input logic v, input logic t,
                      input logic [31:0] a, input logic [31:0] d);
    dmemreq_val   = v;
    dmemreq_type  = t;
    dmemreq_addr  = a;
    dmemreq_wdata = d;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    imemreq_val = 1'b0;
    imemreq_addr = '0;
    dreq(1'b0, 1'b0, 32'h0, 32'h0);
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #2;
    chk("rst_ireq", ireq_count, 32'h0);
    chk("rst_dreq", dreq_count, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_outval", {31'h0, out_val}, 32'h0);
    chk("rst_outdata", out_data, 32'h0);

    // preloads work while reset is held
    preload(32'h0, 32'h0000_0013);
    preload(32'h4, 32'h00A0_0093);
    preload(32'h40, 32'h1234_5678);
    preload(32'h1000, 32'hCAFE_F00D);
    rst = 1'b1;

    imemreq_val = 1'b1;
    imemreq_addr = 32'h0;
    #1 chk("fetch0", imemresp_data, 32'h0000_0013);
    tick();
    imemreq_addr = 32'h4;
    #1 chk("fetch4", imemresp_data, 32'h00A0_0093);
    tick();
    imemreq_val = 1'b0;
    #1 chk("ireq2", ireq_count, 32'd2);
    chk("oor_preload_noerr", {31'h0, err}, 32'h0);

    imemreq_val = 1'b1;
    imemreq_addr = 32'h40;
    dreq(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    #1 chk("rdw_old", imemresp_data, 32'h1234_5678);
    tick();
    imemreq_val = 1'b0;
    dreq(1'b1, 1'b0, 32'h40, 32'h0);
    #1 chk("load40", dmemresp_rdata, 32'hDEAD_BEEF);
    tick();
    dreq(1'b0, 1'b0, 32'h40, 32'h0);
    #1 chk("dreq2", dreq_count, 32'd2);
    chk("dval0_rdata", dmemresp_rdata, 32'h0);
    chk("ireq3", ireq_count, 32'd3);

    dreq(1'b1, 1'b1, 32'h2000, 32'd5);
    tick();
    chk("outval_a", {31'h0, out_val}, 32'h1);
    chk("outdata5", out_data, 32'd5);
    dreq(1'b1, 1'b1, 32'h2000, 32'd7);
    tick();
    chk("outval_b", {31'h0, out_val}, 32'h1);
    chk("outdata7", out_data, 32'd7);
    dreq(1'b1, 1'b0, 32'h2000, 32'h0);
    #1 chk("load_out", dmemresp_rdata, 32'd7);
    tick();
    chk("outval_fall", {31'h0, out_val}, 32'h0);
    chk("mmio_noerr", {31'h0, err}, 32'h0);

    dreq(1'b1, 1'b0, 32'h402, 32'h0);
    #1 chk("misalign_rd0", dmemresp_rdata, 32'h0);
    tick();
    chk("err_set", {31'h0, err}, 32'h1);
    chk("err_addr1", err_addr, 32'h402);
    dreq(1'b1, 1'b1, 32'h400, 32'hFFFF_FFFF);
    tick();
    chk("err_hold", {31'h0, err}, 32'h1);
    chk("err_addr2", err_addr, 32'h402);
    dreq(1'b1, 1'b0, 32'h0, 32'h0);
    #1 chk("word0_intact", dmemresp_rdata, 32'h0000_0013);
    tick();
    dreq(1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk("dreq8", dreq_count, 32'd8);

    dreq(1'b1, 1'b1, 32'h2000, 32'd9);
    tick();
    chk("outdata9", out_data, 32'd9);
    #2 rst = 1'b0;
    #1;
    chk("arst_outval", {31'h0, out_val}, 32'h0);
    chk("arst_outdata", out_data, 32'h0);
    chk("arst_ireq", ireq_count, 32'h0);
    chk("arst_dreq", dreq_count, 32'h0);
    chk("arst_err", {31'h0, err}, 32'h0);
    chk("arst_erraddr", err_addr, 32'h0);
    dreq(1'b1, 1'b1, 32'h0, 32'h0000_0BAD);
    tick();
    chk("rst_noouts", {31'h0, out_val}, 32'h0);
    chk("rst_nocount", dreq_count, 32'h0);
    dreq(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    imemreq_val = 1'b1;
    imemreq_addr = 32'h0;
    #1 chk("post_rst_w0", imemresp_data, 32'h0000_0013);
    imemreq_addr = 32'h4;
    #1 chk("post_rst_w1", imemresp_data, 32'h00A0_0093);
    tick();

    imemreq_addr = 32'h404;
    dreq(1'b1, 1'b0, 32'h1000, 32'h0);
    #1 chk("oor_rd0", dmemresp_rdata, 32'h0);
    chk("oor_fetch0", imemresp_data, 32'h0);
    tick();
    imemreq_val = 1'b0;
    chk("dual_err", {31'h0, err}, 32'h1);
    chk("dual_erraddr", err_addr, 32'h404);
    chk("ireq_post", ireq_count, 32'd2);

    ld_en = 1'b1;
    ld_addr = 32'h8;
    ld_data = 32'h11;
    dreq(1'b1, 1'b1, 32'h8, 32'h22);
    tick();
    ld_en = 1'b0;
    dreq(1'b1, 1'b0, 32'h8, 32'h0);
    #1 chk("conflict", dmemresp_rdata, 32'h11);
    tick();
    dreq(1'b0, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
